// File: rtl/gate_sweep_checker.sv
// Self-test sequencer for the two-input gate stage: sweeps (a,b) through 00..11,
// compares the 7-bit gate results against expected values and reports per-gate pass/fail.
module gate_sweep_checker #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:7] y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:7] fail_mask,
   output logic [4:0] err_count
);

   // state  | meaning
   // IDLE   | waiting for start, results held
   // APPLY  | vector driven, settle counter running down
   // CHECK  | y_in sampled on the exit edge
   // FINISH | one-cycle done pulse
   typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] settle_q, settle_d;
   logic [1:7] fail_mask_q, fail_mask_d;
   logic [4:0] err_count_q, err_count_d;
   logic       pass_q, pass_d;

   logic [1:7] exp_vec;
   logic [1:7] mismatch;
   logic [2:0] mm_cnt;
   logic [4:0] err_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = APPLY;
         APPLY:   if (settle_q == 4'd0) state_d = CHECK;
         CHECK:   state_d = (vec_q == 2'd3) ? FINISH : APPLY;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == APPLY) || (state_q == CHECK);
      done  = (state_q == FINISH);
      a_out = busy & vec_q[1];
      b_out = busy & vec_q[0];
   end

   always_comb begin
      exp_vec[1] = ~vec_q[1];
      exp_vec[2] = vec_q[1] & vec_q[0];
      exp_vec[3] = vec_q[1] | vec_q[0];
      exp_vec[4] = vec_q[1] ^ vec_q[0];
      exp_vec[5] = ~(vec_q[1] & vec_q[0]);
      exp_vec[6] = ~(vec_q[1] | vec_q[0]);
      exp_vec[7] = ~(vec_q[1] ^ vec_q[0]);
      mismatch   = y_in ^ exp_vec;
      mm_cnt     = 3'd0;
      for (int i = 1; i <= 7; i++) mm_cnt = mm_cnt + 3'(mismatch[i]);
      err_sum    = err_count_q + {2'b00, mm_cnt};
   end

   always_comb begin
      vec_d       = vec_q;
      settle_d    = settle_q;
      fail_mask_d = fail_mask_q;
      err_count_d = err_count_q;
      pass_d      = pass_q;
      case (state_q)
         IDLE: if (start) begin
            vec_d       = 2'd0;
            settle_d    = SETTLE_LOAD;
            fail_mask_d = '0;
            err_count_d = '0;
            pass_d      = 1'b0;
         end
         APPLY: if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
         CHECK: begin
            fail_mask_d = fail_mask_q | mismatch;
            err_count_d = err_sum;
            if (vec_q != 2'd3) begin
               vec_d    = vec_q + 2'd1;
               settle_d = SETTLE_LOAD;
            end else begin
               // Registered on entry to FINISH so pass is already valid while done is high.
               pass_d = (err_sum == 5'd0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q       <= 2'd0;
         settle_q    <= 4'd0;
         fail_mask_q <= '0;
         err_count_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         vec_q       <= vec_d;
         settle_q    <= settle_d;
         fail_mask_q <= fail_mask_d;
         err_count_q <= err_count_d;
         pass_q      <= pass_d;
      end
   end

   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: S=1 and S=3 instances, fault-injecting gate model,
// sweep-level reference model of the expected summary.
module tb_gate_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start1, start3;
   logic [1:7] y1, y3, fm1, fm3;
   logic       a1, b1, busy1, done1, pass1;
   logic       a3, b3, busy3, done3, pass3;
   logic [4:0] err1, err3;

   logic [1:7] xm [4];
   logic [1:7] clr_m, set_m;

   int checks   = 0;
   int failures = 0;
   int cur      = 1;

   function automatic logic [1:7] gate(input logic a, input logic b);
      logic [1:7] g;
      g[1] = ~a;
      g[2] = a & b;
      g[3] = a | b;
      g[4] = a ^ b;
      g[5] = ~(a & b);
      g[6] = ~(a | b);
      g[7] = ~(a ^ b);
      return g;
   endfunction

   assign y1 = ((gate(a1, b1) ^ xm[{a1, b1}]) & ~clr_m) | set_m;
   assign y3 = gate(a3, b3);

   gate_sweep_checker #(.SETTLE_CYCLES(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start1), .y_in(y1),
      .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
      .pass(pass1), .fail_mask(fm1), .err_count(err1)
   );

   gate_sweep_checker #(.SETTLE_CYCLES(3)) u_s3 (
      .clk(clk), .rst(rst), .start(start3), .y_in(y3),
      .a_out(a3), .b_out(b3), .busy(busy3), .done(done3),
      .pass(pass3), .fail_mask(fm3), .err_count(err3)
   );

   logic       oa, ob, obusy, odone, opass;
   logic [1:7] ofm;
   logic [4:0] oerr;
   assign oa    = (cur == 1) ? a1    : a3;
   assign ob    = (cur == 1) ? b1    : b3;
   assign obusy = (cur == 1) ? busy1 : busy3;
   assign odone = (cur == 1) ? done1 : done3;
   assign opass = (cur == 1) ? pass1 : pass3;
   assign ofm   = (cur == 1) ? fm1   : fm3;
   assign oerr  = (cur == 1) ? err1  : err3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_fault();
      for (int i = 0; i < 4; i++) xm[i] = '0;
      clr_m = '0;
      set_m = '0;
   endtask

   // Reference: compare the faulty gate stage against the true gate table over all four vectors.
   task automatic model_sweep(output logic [1:7] efm, output int eerr, output bit epass);
      logic [1:7] good, got, mm;
      logic [1:0] vv;
      efm  = '0;
      eerr = 0;
      for (int v = 0; v < 4; v++) begin
         vv   = 2'(v);
         good = gate(vv[1], vv[0]);
         got  = ((good ^ xm[v]) & ~clr_m) | set_m;
         mm   = good ^ got;
         efm  = efm | mm;
         eerr = eerr + $countones(mm);
      end
      epass = (eerr == 0);
   endtask

   task automatic drive_start(input int inst, input logic v);
      if (inst == 1) start1 = v;
      else           start3 = v;
   endtask

   task automatic sweep(input int inst, input bit mid_pulse);
      int         s, per, nn, eerr;
      logic [1:0] ev;
      logic [1:7] efm;
      bit         epass;
      s   = (inst == 1) ? 1 : 3;
      per = s + 1;
      nn  = 4 * per;
      cur = inst;
      if (inst == 1) model_sweep(efm, eerr, epass);
      else begin efm = '0; eerr = 0; epass = 1'b1; end
      @(negedge clk); drive_start(inst, 1'b1);
      @(negedge clk); drive_start(inst, 1'b0);
      for (int n = 0; n <= nn + 6; n++) begin
         if (n < nn) begin
            ev = 2'(n / per);
            chk("ab", {oa, ob}, ev);
            chk("busy", obusy, 1);
            chk("done_early", odone, 0);
            if (n == 0) begin
               chk("clr_err", oerr, 0);
               chk("clr_mask", ofm, 0);
               chk("clr_pass", opass, 0);
            end
         end else begin
            chk("busy_end", obusy, 0);
            chk("ab_idle", {oa, ob}, 0);
            chk("done", odone, (n == nn));
            chk("pass", opass, epass);
            chk("fail_mask", ofm, efm);
            chk("err_count", oerr, eerr);
         end
         if (mid_pulse && n == 5) drive_start(inst, 1'b1);
         if (mid_pulse && n == 6) drive_start(inst, 1'b0);
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0; start1 = 1'b0; start3 = 1'b0; cur = 1;
      clear_fault();
      #2 rst = 1'b1;
      #1;
      chk("rst_ab", {a1, b1}, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_pass", pass1, 0);
      chk("rst_mask", fm1, 0);
      chk("rst_err", err1, 0);
      chk("rst_busy3", busy3, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_hold", {a1, b1, busy1, done1, pass1, fm1, err1}, 0);
      end

      sweep(1, 1'b0);

      clear_fault(); clr_m = 7'b0100000;
      sweep(1, 1'b0);

      clear_fault(); for (int i = 0; i < 4; i++) xm[i] = 7'b0001000;
      sweep(1, 1'b0);

      clear_fault(); set_m = 7'b1000000;
      sweep(1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         clear_fault();
         for (int i = 0; i < 4; i++)
            xm[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
         if ($urandom_range(0, 3) == 0) clr_m = 7'($urandom) & 7'($urandom);
         if ($urandom_range(0, 3) == 0) set_m = 7'($urandom) & 7'($urandom);
         sweep(1, 1'b0);
      end
      clear_fault();

      sweep(3, 1'b1);

      // start held high: 16 busy cycles, the done cycle, then one IDLE cycle before re-acceptance.
      cur = 3;
      @(negedge clk); start3 = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 54; n++) begin
         chk("hold_busy", busy3, ((n % 18) < 16));
         chk("hold_done", done3, ((n % 18) == 16));
         if ((n % 18) == 0) chk("hold_clr_pass", pass3, 0);
         if ((n % 18) == 16) begin
            chk("hold_pass", pass3, 1);
            chk("hold_err", err3, 0);
         end
         if (n == 53) start3 = 1'b0;
         @(negedge clk);
      end
      repeat (3) begin
         chk("hold_stop", busy3, 0);
         @(negedge clk);
      end

      cur = 1;
      clear_fault(); xm[0] = 7'b1111111; xm[1] = 7'b0000011;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_ab", {a1, b1}, 2'b10);
      chk("pre_rst_err", err1, 9);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ab", {a1, b1}, 0);
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_mask", fm1, 0);
      chk("mid_rst_err", err1, 0);
      chk("mid_rst_pass", pass1, 0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("post_rst_done", done1, 0);
         chk("post_rst_busy", busy1, 0);
         @(negedge clk);
      end
      clear_fault();
      sweep(1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
